// File: rtl/dct_transpose_sched.sv
// Transpose scheduler between the row and column passes of an 8x8 2D-DCT.
// Serial row-pass coefficients are written row-major into one of two 64-entry
// banks. Each full bank is then read out one column per beat: 8 coefficients
// packed together, lane r holding row r.
//
// Ports
//   clk_i, rst_n_i                         clock, async active-low reset
//   in_tdata/tvalid/tready/tuser/tlast     serial row-pass stream (tuser = beat 0, tlast = beat 63)
//   out_tdata/tvalid/tready/tuser/tlast    column stream (tuser = column 0, tlast = column 7)
//   sync_err_o                             one-cycle pulse when tuser arrives mid-block
module dct_transpose_sched #(
    parameter int unsigned COEF_WIDTH = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [COEF_WIDTH-1:0]     in_tdata,
    input  logic                      in_tvalid,
    output logic                      in_tready,
    input  logic                      in_tuser,
    input  logic                      in_tlast,
    output logic [8*COEF_WIDTH-1:0]   out_tdata,
    output logic                      out_tvalid,
    input  logic                      out_tready,
    output logic                      out_tuser,
    output logic                      out_tlast,
    output logic                      sync_err_o
);

    localparam int unsigned N_LANES = 8;
    localparam int unsigned OUT_W   = N_LANES * COEF_WIDTH;
    localparam int unsigned IDX_W   = 6;

    // Buffer storage: [bank][row][col]; deliberately not reset.
    logic [COEF_WIDTH-1:0] r_mem [2][N_LANES][N_LANES];

    logic [1:0]       r_full;
    logic [1:0]       r_sof;
    logic [1:0]       r_eol;
    logic             r_wr_bank;
    logic [IDX_W-1:0] r_wr_idx;
    logic             r_rd_bank;
    logic [2:0]       r_rd_col;
    // Holds in_tready low until the first clock after reset release.
    logic             r_run;

    logic             w_in_hs;
    logic             w_resync;
    logic             w_wr_last;
    logic [2:0]       w_wr_row;
    logic [2:0]       w_wr_col;
    logic             w_rd_load;
    logic             w_rd_last;
    logic [1:0]       w_full_set;
    logic [1:0]       w_full_clr;
    logic [OUT_W-1:0] w_col;

    assign in_tready = r_run && !r_full[r_wr_bank];
    assign w_in_hs   = in_tvalid && in_tready;

    // A start-of-frame mid-block restarts the current bank at index 0.
    assign w_resync  = w_in_hs && in_tuser && (r_wr_idx != '0);
    assign w_wr_last = w_in_hs && !w_resync && (r_wr_idx == IDX_W'(63));
    assign w_wr_row  = w_resync ? 3'd0 : r_wr_idx[5:3];
    assign w_wr_col  = w_resync ? 3'd0 : r_wr_idx[2:0];

    assign w_rd_load = r_full[r_rd_bank] && (!out_tvalid || out_tready);
    assign w_rd_last = w_rd_load && (r_rd_col == 3'd7);

    // Write side only sets a non-full bank, read side only clears a full one,
    // so the two masks never overlap.
    assign w_full_set = w_wr_last ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_full_clr = w_rd_last ? (2'b01 << r_rd_bank) : 2'b00;

    // Column gather: lane r is row r of the selected column.
    for (genvar g = 0; g < N_LANES; g++) begin : g_col
        assign w_col[g*COEF_WIDTH +: COEF_WIDTH] = r_mem[r_rd_bank][g][r_rd_col];
    end

    // Buffer write port.
    always_ff @(posedge clk_i) begin
        if (w_in_hs) begin
            r_mem[r_wr_bank][w_wr_row][w_wr_col] <= in_tdata;
        end
    end

    // Write-side control and bank ownership.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_run      <= 1'b0;
            r_full     <= 2'b00;
            r_sof      <= 2'b00;
            r_eol      <= 2'b00;
            r_wr_bank  <= 1'b0;
            r_wr_idx   <= '0;
            sync_err_o <= 1'b0;
        end else begin
            r_run      <= 1'b1;
            r_full     <= (r_full | w_full_set) & ~w_full_clr;
            sync_err_o <= w_resync;
            if (w_resync) begin
                r_sof[r_wr_bank] <= 1'b1;
                r_wr_idx         <= IDX_W'(1);
            end else if (w_in_hs) begin
                if (r_wr_idx == '0) begin
                    r_sof[r_wr_bank] <= in_tuser;
                end
                if (w_wr_last) begin
                    r_eol[r_wr_bank] <= in_tlast;
                    r_wr_bank        <= ~r_wr_bank;
                end
                r_wr_idx <= r_wr_idx + IDX_W'(1);
            end
        end
    end

    // Registered output stage; holds its contents while stalled.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_tdata  <= '0;
            out_tvalid <= 1'b0;
            out_tuser  <= 1'b0;
            out_tlast  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_rd_col   <= 3'd0;
        end else if (w_rd_load) begin
            out_tdata  <= w_col;
            out_tvalid <= 1'b1;
            out_tuser  <= r_sof[r_rd_bank] && (r_rd_col == 3'd0);
            out_tlast  <= r_eol[r_rd_bank] && (r_rd_col == 3'd7);
            r_rd_col   <= r_rd_col + 3'd1;
            if (r_rd_col == 3'd7) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end else if (out_tready) begin
            out_tvalid <= 1'b0;
            out_tuser  <= 1'b0;
            out_tlast  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dct_transpose_sched.sv
// Directed bench for dct_transpose_sched: ordering, latency, backpressure,
// frame markers, resync and mid-stream reset.
module tb_dct_transpose_sched;

    localparam int unsigned CW = 16;
    localparam int unsigned OW = 8 * CW;

    logic          clk;
    logic          rst_n;
    logic [CW-1:0] in_tdata;
    logic          in_tvalid;
    logic          in_tready;
    logic          in_tuser;
    logic          in_tlast;
    logic [OW-1:0] out_tdata;
    logic          out_tvalid;
    logic          out_tready;
    logic          out_tuser;
    logic          out_tlast;
    logic          sync_err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_in_hs = 0;
    int n_stall = 0;
    int n_sync  = 0;

    logic [OW-1:0] q_data [$];
    logic          q_user [$];
    logic          q_last [$];

    dct_transpose_sched #(.COEF_WIDTH(CW)) u_dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .in_tdata   (in_tdata),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .in_tuser   (in_tuser),
        .in_tlast   (in_tlast),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tuser  (out_tuser),
        .out_tlast  (out_tlast),
        .sync_err_o (sync_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observe handshakes mid-cycle; inputs only change just after posedge.
    always @(negedge clk) begin
        if (out_tvalid && out_tready) begin
            q_data.push_back(out_tdata);
            q_user.push_back(out_tuser);
            q_last.push_back(out_tlast);
        end
        if (in_tvalid && in_tready)  n_in_hs++;
        if (in_tvalid && !in_tready) n_stall++;
        if (sync_err)                n_sync++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Column c of a block whose beat k carried base+k: lane r = base + 8r + c.
    function automatic logic [OW-1:0] col_exp(input int base, input int c);
        logic [OW-1:0] v;
        v = '0;
        for (int r = 0; r < 8; r++) v[r*CW +: CW] = CW'(base + 8*r + c);
        return v;
    endfunction

    task automatic send_beat(input int d, input logic u, input logic l);
        bit done;
        done      = 1'b0;
        in_tdata  = CW'(d);
        in_tuser  = u;
        in_tlast  = l;
        in_tvalid = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (in_tready) done = 1'b1;
        end
        if (!done) chk("send_ready", OW'(done), OW'(1));
        @(posedge clk);
        #1;
        in_tvalid = 1'b0;
        in_tuser  = 1'b0;
        in_tlast  = 1'b0;
    endtask

    task automatic send_block(input int base, input logic u, input logic l, input int stray);
        for (int k = 0; k < 64; k++)
            send_beat(base + k, u && (k == 0), (l && (k == 63)) || (k == stray));
    endtask

    task automatic wait_out(input int start, input int n, input string tag);
        for (int i = 0; i < 800 && q_data.size() < start + n; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (10) @(posedge clk);
        #1;
        chk(tag, OW'(q_data.size() - start), OW'(n));
    endtask

    task automatic check_block(input int start, input int base, input logic u, input logic l,
                               input string tag);
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("%s_data_c%0d", tag, c), q_data[start+c], col_exp(base, c));
            chk($sformatf("%s_user_c%0d", tag, c), OW'(q_user[start+c]), OW'(u && (c == 0)));
            chk($sformatf("%s_last_c%0d", tag, c), OW'(q_last[start+c]), OW'(l && (c == 7)));
        end
    endtask

    initial begin
        int qs;
        int snap;

        rst_n      = 1'b0;
        in_tdata   = '0;
        in_tvalid  = 1'b0;
        in_tuser   = 1'b0;
        in_tlast   = 1'b0;
        out_tready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_tready", OW'(in_tready), OW'(0));
        chk("rst_out_tvalid", OW'(out_tvalid), OW'(0));
        chk("rst_out_tdata", out_tdata, OW'(0));
        chk("rst_sync_err", OW'(sync_err), OW'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready_after", OW'(in_tready), OW'(1));

        // 1: single block, transpose and latency
        qs = q_data.size();
        send_block(0, 1'b0, 1'b0, -1);
        chk("t1_lat_pre", OW'(out_tvalid), OW'(0));
        @(posedge clk);
        #1;
        chk("t1_lat_valid", OW'(out_tvalid), OW'(1));
        chk("t1_lat_col0", out_tdata, col_exp(0, 0));
        wait_out(qs, 8, "t1_count");
        check_block(qs, 0, 1'b0, 1'b0, "t1");

        // 2: three blocks back to back, no input stall
        qs   = q_data.size();
        snap = n_stall;
        send_block(100, 1'b1, 1'b1, -1);
        send_block(200, 1'b1, 1'b1, -1);
        send_block(300, 1'b1, 1'b1, -1);
        wait_out(qs, 24, "t2_count");
        chk("t2_stall", OW'(n_stall - snap), OW'(0));
        check_block(qs,      100, 1'b1, 1'b1, "t2b0");
        check_block(qs + 8,  200, 1'b1, 1'b1, "t2b1");
        check_block(qs + 16, 300, 1'b1, 1'b1, "t2b2");

        // 3: output stalled, exactly 128 beats accepted
        qs         = q_data.size();
        out_tready = 1'b0;
        snap       = n_in_hs;
        send_block(1000, 1'b0, 1'b0, -1);
        send_block(1100, 1'b0, 1'b0, -1);
        in_tdata  = CW'(1200);
        in_tvalid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("t3_accepted", OW'(n_in_hs - snap), OW'(128));
        chk("t3_blocked", OW'(in_tready), OW'(0));
        chk("t3_hold_valid", OW'(out_tvalid), OW'(1));
        chk("t3_hold_data", out_tdata, col_exp(1000, 0));
        out_tready = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk);
            #1;
            if (i == 6) chk("t3_ready_pre", OW'(in_tready), OW'(0));
            if (i == 7) begin
                chk("t3_ready_post", OW'(in_tready), OW'(1));
                chk("t3_col7", out_tdata, col_exp(1000, 7));
            end
        end
        send_block(1200, 1'b0, 1'b0, -1);
        wait_out(qs, 24, "t3_count");
        check_block(qs,      1000, 1'b0, 1'b0, "t3b0");
        check_block(qs + 8,  1100, 1'b0, 1'b0, "t3b1");
        check_block(qs + 16, 1200, 1'b0, 1'b0, "t3b2");

        // 4: frame markers, stray tlast on beat 10 ignored
        qs = q_data.size();
        send_block(2000, 1'b1, 1'b1, 10);
        send_block(2100, 1'b1, 1'b0, 10);
        wait_out(qs, 16, "t4_count");
        check_block(qs,     2000, 1'b1, 1'b1, "t4a");
        check_block(qs + 8, 2100, 1'b1, 1'b0, "t4b");

        // 5: tuser on beat 20 restarts the block
        qs   = q_data.size();
        snap = n_sync;
        for (int k = 0; k < 20; k++) send_beat(3000 + k, k == 0, 1'b0);
        send_beat(3100, 1'b1, 1'b0);
        chk("t5_pulse", OW'(sync_err), OW'(1));
        for (int k = 1; k < 64; k++) send_beat(3100 + k, 1'b0, k == 63);
        wait_out(qs, 8, "t5_count");
        chk("t5_pulses", OW'(n_sync - snap), OW'(1));
        check_block(qs, 3100, 1'b1, 1'b1, "t5");

        // 6: reset with one bank full, 30 beats in the other, output valid
        out_tready = 1'b0;
        send_block(4000, 1'b1, 1'b1, -1);
        for (int k = 0; k < 30; k++) send_beat(4100 + k, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("t6_pre_valid", OW'(out_tvalid), OW'(1));
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_in_tready", OW'(in_tready), OW'(0));
        chk("t6_out_tvalid", OW'(out_tvalid), OW'(0));
        chk("t6_out_tdata", out_tdata, OW'(0));
        chk("t6_out_tuser", OW'(out_tuser), OW'(0));
        chk("t6_out_tlast", OW'(out_tlast), OW'(0));
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        out_tready = 1'b1;
        qs         = q_data.size();
        send_block(5000, 1'b1, 1'b1, -1);
        wait_out(qs, 8, "t6_count");
        check_block(qs, 5000, 1'b1, 1'b1, "t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
